ct_spsram_pipe_wrap: RTL and testbench
======================================

// Module: ct_spsram_pipe_wrap
// PURPOSE
//  Parametrised single-port SRAM wrapper: behavioural array + self-clearing init FSM,
//  group-granular active-low write mask, optional output register stage, read-valid strobe.
//  Successor to the fixed-size spsram wrappers; drops into IFU/LSU array slots of any depth/width.
// PARAMETERS
//  ADDR_WIDTH  10  address bits; depth = 2**ADDR_WIDTH
//  DATA_WIDTH  59  data bits per entry
//  WE_WIDTH    59  write-mask groups; DATA_WIDTH % WE_WIDTH == 0; group = DATA_WIDTH/WE_WIDTH bits
//  OUT_REG     0   0: read data after 1 cycle; 1: extra output flop, read data after 2 cycles
//  INIT_VALUE  0   DATA_WIDTH-bit value written to every entry by the init FSM
// PORTS
//  forever_cpuclk  in   1           clock
//  cpurst_b        in   1           asynchronous reset, active low
//  A               in   ADDR_WIDTH  address
//  CEN             in   1           chip enable, active low
//  GWEN            in   1           global write enable, active low (0=write, 1=read)
//  WEN             in   WE_WIDTH    per-group write enable, active low
//  D               in   DATA_WIDTH  write data
//  Q               out  DATA_WIDTH  read data
//  rd_vld          out  1           Q carries fresh read data this cycle
//  init_done       out  1           array cleared; accesses accepted
//  parity_err      out  1           parity mismatch on the group(s) of current read
// BEHAVIOUR
//  - Reset (async, cpurst_b=0): Q=0, rd_vld=0, init_done=0, parity_err=0, FSM->INIT, cnt=0.
//  - FSM INIT: writes INIT_VALUE (and matching parity) to entry cnt each cycle, cnt++;
//    at cnt==2**ADDR_WIDTH-1 write last entry, next cycle FSM->READY, init_done=1.
//    Init takes exactly 2**ADDR_WIDTH cycles after reset release. CEN/GWEN/WEN ignored in INIT.
//  - READY, access when CEN=0:
//    GWEN=0: groups with WEN[g]=0 take D group g; others keep old data. Q, rd_vld unchanged.
//    GWEN=1: read A. OUT_REG=0: Q=mem[A], rd_vld=1 next cycle. OUT_REG=1: one cycle later.
//  - CEN=1 or write: rd_vld=0 in the matching output cycle; Q holds last read value.
//  - Back-to-back reads fully pipelined, one per cycle; no stalls, no ready signal.
//  - Write then read of same address next cycle returns new data (array is write-first
//    across cycles; no same-cycle read/write possible on single port).
//  - GWEN=0 with WEN all-ones: no state change (legal no-op).
//  - Address wrap: A indexes modulo depth by construction; no out-of-range check.
//  - Reset mid-operation: in-flight reads dropped (rd_vld=0), FSM restarts INIT from cnt=0.
// CONFIGURATION
//  CT_SPSRAM_PARITY_EN defined: one even-parity bit per write group stored alongside data,
//   computed from D on write (INIT_VALUE on init); on read, parity_err=1 with rd_vld when
//   any group mismatches; parity_err aligned with Q, registered by OUT_REG like Q.
//  Not defined: no parity storage/logic; parity_err tied 0.
// STRUCTURE
//  Package ct_spsram_pkg: FSM state enum {INIT, READY}; function grp_parity(data,groups)
//   returning WE_WIDTH parity bits.
//  Sub-module ct_spsram_init_ctrl: INIT/READY FSM + address counter; outputs init_wr,
//   init_addr, init_done. Top muxes init vs. user port into array.
// TESTING
//  1 ADDR_WIDTH=4,INIT_VALUE=0x5: release reset -> init_done rises after exactly 16 cycles;
//    read all 16 -> Q=0x5, rd_vld=1 each.
//  2 Write A=3 D=all-ones WEN=0 ; read A=3 -> Q=all-ones, 1 cycle (OUT_REG=0), 2 cycles (OUT_REG=1).
//  3 WE_WIDTH=DATA_WIDTH: write A=7 D=0 full, then D=all-ones with WEN[0]=0 only -> read Q=0x1.
//  4 Reads A=0,1,2 back-to-back then CEN=1 -> rd_vld 1,1,1,0; Q holds A=2 data.
//  5 Assert cpurst_b=0 mid-read burst -> rd_vld=0, Q=0, init_done=0; init reruns; CEN ignored.
//  6 PARITY_EN: force flip one stored bit at A=5 -> read A=5 gives parity_err=1 with rd_vld;
//    without macro parity_err stays 0.

Source files
------------

// File: rtl/ct_spsram_pkg.sv
// Shared types and helpers for the ct_spsram wrapper family.
// Optional feature macro: CT_SPSRAM_PARITY_EN (group parity storage/check).
package ct_spsram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } init_state_t;

    // Widest data word / group count the parity helper can handle.
    localparam int unsigned PAR_MAX_W = 1024;

    // Even parity per write group: bit g is the XOR of data bits
    // [g*gw +: gw], gw = dw/groups. Bits at or above 'groups' are zero.
    function automatic logic [PAR_MAX_W-1:0] grp_parity(
        input logic [PAR_MAX_W-1:0] data,
        input int unsigned          dw,
        input int unsigned          groups
    );
        logic [PAR_MAX_W-1:0] p;
        int unsigned          gw;
        p  = '0;
        gw = dw / groups;
        for (int unsigned i = 0; i < PAR_MAX_W; i++) begin
            if (i < dw) p[i / gw] = p[i / gw] ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/ct_spsram_init_ctrl.sv
// Self-clearing init sequencer: walks every array entry once after reset,
// then parks in READY and opens the user port.
module ct_spsram_init_ctrl
    import ct_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  gclk,
    input  logic                  grst_n,
    output logic                  init_wr,
    output logic [ADDR_WIDTH-1:0] init_addr,
    output logic                  init_done
);

    init_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;

    // State register and entry counter; counter only advances while clearing.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) cnt <= cnt + 1'b1;
        end
    end

    // Leave INIT on the same edge that writes the last entry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (&cnt) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_INIT;
        endcase
    end

    assign init_wr   = (state == ST_INIT);
    assign init_addr = cnt;
    assign init_done = (state == ST_READY);

endmodule

// File: rtl/ct_spsram_pipe_wrap.sv
// Parametrised single-port SRAM wrapper: behavioural array, init sequencer,
// group write mask, 1- or 2-cycle read pipeline with valid strobe.
// Optional feature macro: CT_SPSRAM_PARITY_EN (one even-parity bit per group).
module ct_spsram_pipe_wrap
    import ct_spsram_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 10,
    parameter int                  DATA_WIDTH = 59,
    parameter int                  WE_WIDTH   = 59,
    parameter int                  OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  rd_vld,
    output logic                  init_done,
    output logic                  parity_err
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int GRP_W  = DATA_WIDTH / WE_WIDTH;
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    logic                  init_wr;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  user_wr, user_rd;
    logic [DATA_WIDTH-1:0] bit_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ct_spsram_init_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_init_ctrl (
        .gclk      (forever_cpuclk),
        .grst_n    (cpurst_b),
        .init_wr   (init_wr),
        .init_addr (init_addr),
        .init_done (init_done)
    );

    // User port is ignored until the array has been cleared.
    assign user_wr = init_done & ~CEN & ~GWEN;
    assign user_rd = init_done & ~CEN &  GWEN;

    // Expand active-low group enables into a per-bit write mask.
    for (genvar g = 0; g < WE_WIDTH; g++) begin : g_bit_en
        assign bit_en[g*GRP_W +: GRP_W] = {GRP_W{~WEN[g]}};
    end

    // Data array: init sequencer owns the port while clearing.
    always_ff @(posedge forever_cpuclk) begin
        if (init_wr)
            mem[init_addr] <= INIT_VALUE;
        else if (user_wr)
            mem[A] <= (mem[A] & ~bit_en) | (D & bit_en);
    end

    // Read pipeline: stage 0 is the array output, stage STAGES drives Q.
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0] q_pipe;

    assign vld_pipe[0] = user_rd;
    assign q_pipe[0]   = mem[A];

    // Each stage only loads on a valid read so Q holds the last read value.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld_pipe[STAGES:1] <= '0;
            q_pipe[STAGES:1]   <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) q_pipe[s] <= q_pipe[s-1];
            end
        end
    end

    assign Q      = q_pipe[STAGES];
    assign rd_vld = vld_pipe[STAGES];

`ifdef CT_SPSRAM_PARITY_EN
    logic [WE_WIDTH-1:0]  par_mem [DEPTH];
    logic [PAR_MAX_W-1:0] par_d_full, par_init_full, par_rd_full;
    logic [WE_WIDTH-1:0]  par_d, par_init, par_rd;
    logic [STAGES:0]      perr_pipe;

    assign par_d_full    = grp_parity(PAR_MAX_W'(D), DATA_WIDTH, WE_WIDTH);
    assign par_init_full = grp_parity(PAR_MAX_W'(INIT_VALUE), DATA_WIDTH, WE_WIDTH);
    assign par_rd_full   = grp_parity(PAR_MAX_W'(mem[A]), DATA_WIDTH, WE_WIDTH);
    assign par_d         = par_d_full[WE_WIDTH-1:0];
    assign par_init      = par_init_full[WE_WIDTH-1:0];
    assign par_rd        = par_rd_full[WE_WIDTH-1:0];

    // Parity array follows the data array, masked per group.
    always_ff @(posedge forever_cpuclk) begin
        if (init_wr)
            par_mem[init_addr] <= par_init;
        else if (user_wr)
            par_mem[A] <= (par_mem[A] & WEN) | (par_d & ~WEN);
    end

    assign perr_pipe[0] = |(par_rd ^ par_mem[A]);

    // Error flag rides the read pipeline and is only raised alongside a valid.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            perr_pipe[STAGES:1] <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++)
                perr_pipe[s] <= vld_pipe[s-1] & perr_pipe[s-1];
        end
    end

    assign parity_err = perr_pipe[STAGES];
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ct_spsram_pipe_wrap.sv
// Directed bench: two wrappers (OUT_REG=0 and OUT_REG=1) share one stimulus
// stream; each scenario task checks both against hand-computed values.
module tb_ct_spsram_pipe_wrap;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] a = '0;
    logic          cen = 1'b1;
    logic          gwen = 1'b1;
    logic [WW-1:0] wen = '1;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] q0, q1;
    logic          v0, v1, done0, done1, pe0, pe1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ct_spsram_pipe_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
                          .OUT_REG(0), .INIT_VALUE(8'h05)) dut0 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen),
        .WEN(wen), .D(d), .Q(q0), .rd_vld(v0), .init_done(done0), .parity_err(pe0));

    ct_spsram_pipe_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW),
                          .OUT_REG(1), .INIT_VALUE(8'h05)) dut1 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen),
        .WEN(wen), .D(d), .Q(q1), .rd_vld(v1), .init_done(done1), .parity_err(pe1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [WW-1:0] mask_n);
        a = addr; d = data; wen = mask_n; cen = 1'b0; gwen = 1'b0;
        tick();
        cen = 1'b1; gwen = 1'b1; wen = '1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (q0 !== 8'h00 || v0 !== 1'b0 || done0 !== 1'b0 || pe0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut0 got q=%h vld=%b done=%b perr=%b want 00 0 0 0", q0, v0, done0, pe0);
        end
        checks++;
        if (q1 !== 8'h00 || v1 !== 1'b0 || done1 !== 1'b0 || pe1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut1 got q=%h vld=%b done=%b perr=%b want 00 0 0 0", q1, v1, done1, pe1);
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (done0 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL %s_cycles got %0d want 16", tag, n);
        end
        checks++;
        if (done1 !== 1'b1) begin
            failures++;
            $display("FAIL %s_done1 got %b want 1", tag, done1);
        end
    endtask

    task automatic test_init;
        rst_n = 1'b1;
        wait_init("init");
        for (int i = 0; i < 16; i++) begin
            a = AW'(i); cen = 1'b0; gwen = 1'b1;
            tick();
            checks++;
            if (q0 !== 8'h05 || v0 !== 1'b1 || pe0 !== 1'b0) begin
                failures++;
                $display("FAIL init_rd0[%0d] got q=%h vld=%b perr=%b want 05 1 0", i, q0, v0, pe0);
            end
            if (i > 0) begin
                checks++;
                if (q1 !== 8'h05 || v1 !== 1'b1) begin
                    failures++;
                    $display("FAIL init_rd1[%0d] got q=%h vld=%b want 05 1", i - 1, q1, v1);
                end
            end
        end
        cen = 1'b1;
        tick();
        checks++;
        if (v0 !== 1'b0 || q1 !== 8'h05 || v1 !== 1'b1) begin
            failures++;
            $display("FAIL init_tail got v0=%b q1=%h v1=%b want 0 05 1", v0, q1, v1);
        end
        tick();
        checks++;
        if (v1 !== 1'b0 || q1 !== 8'h05) begin
            failures++;
            $display("FAIL init_idle1 got v1=%b q1=%h want 0 05", v1, q1);
        end
    endtask

    task automatic test_write_read;
        do_write(4'd3, 8'hFF, 8'h00);
        checks++;
        if (v0 !== 1'b0 || q0 !== 8'h05) begin
            failures++;
            $display("FAIL wr_no_vld got v0=%b q0=%h want 0 05", v0, q0);
        end
        a = 4'd3; cen = 1'b0; gwen = 1'b1;
        tick();
        cen = 1'b1;
        checks++;
        if (q0 !== 8'hFF || v0 !== 1'b1) begin
            failures++;
            $display("FAIL wr_rd0 got q=%h vld=%b want ff 1", q0, v0);
        end
        checks++;
        if (q1 !== 8'h05 || v1 !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd1_early got q=%h vld=%b want 05 0", q1, v1);
        end
        tick();
        checks++;
        if (q1 !== 8'hFF || v1 !== 1'b1 || v0 !== 1'b0 || q0 !== 8'hFF) begin
            failures++;
            $display("FAIL wr_rd1 got q1=%h v1=%b v0=%b q0=%h want ff 1 0 ff", q1, v1, v0, q0);
        end
    endtask

    task automatic read7(input logic [DW-1:0] exp, input string tag);
        a = 4'd7; cen = 1'b0; gwen = 1'b1;
        tick();
        cen = 1'b1;
        checks++;
        if (q0 !== exp || v0 !== 1'b1) begin
            failures++;
            $display("FAIL %s_dut0 got q=%h vld=%b want %h 1", tag, q0, v0, exp);
        end
        tick();
        checks++;
        if (q1 !== exp || v1 !== 1'b1) begin
            failures++;
            $display("FAIL %s_dut1 got q=%h vld=%b want %h 1", tag, q1, v1, exp);
        end
    endtask

    task automatic test_partial_write;
        do_write(4'd7, 8'h00, 8'h00);
        do_write(4'd7, 8'hFF, 8'hFE);
        read7(8'h01, "wen_bit0");
        do_write(4'd7, 8'hAA, 8'hFF);
        read7(8'h01, "wen_noop");
        do_write(4'd7, 8'hF0, 8'h0F);
        read7(8'hF1, "wen_upper");
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_q [4];
        logic          exp_v [4];
        exp_q = '{8'h05, 8'h05, 8'h3C, 8'h3C};
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b0};
        do_write(4'd2, 8'h3C, 8'h00);
        for (int i = 0; i < 4; i++) begin
            a = AW'(i); cen = (i == 3); gwen = 1'b1;
            tick();
            checks++;
            if (q0 !== exp_q[i] || v0 !== exp_v[i]) begin
                failures++;
                $display("FAIL b2b_dut0[%0d] got q=%h vld=%b want %h %b", i, q0, v0, exp_q[i], exp_v[i]);
            end
            if (i > 0) begin
                checks++;
                if (q1 !== exp_q[i-1] || v1 !== exp_v[i-1]) begin
                    failures++;
                    $display("FAIL b2b_dut1[%0d] got q=%h vld=%b want %h %b", i - 1, q1, v1, exp_q[i-1], exp_v[i-1]);
                end
            end
        end
        tick();
        checks++;
        if (q1 !== 8'h3C || v1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_dut1_tail got q=%h vld=%b want 3c 0", q1, v1);
        end
    endtask

    task automatic test_reset_mid;
        a = 4'd0; cen = 1'b0; gwen = 1'b1;
        tick();
        a = 4'd1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (q0 !== 8'h00 || v0 !== 1'b0 || done0 !== 1'b0 || q1 !== 8'h00 || v1 !== 1'b0 || done1 !== 1'b0) begin
            failures++;
            $display("FAIL midrst got q0=%h v0=%b d0=%b q1=%h v1=%b d1=%b want all 0", q0, v0, done0, q1, v1, done1);
        end
        // Keep hammering writes during init; they must be ignored.
        a = 4'd4; d = 8'hEE; wen = 8'h00; cen = 1'b0; gwen = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_init("reinit");
        wen = '1; gwen = 1'b1; cen = 1'b0; a = 4'd4;
        tick();
        checks++;
        if (q0 !== 8'h05 || v0 !== 1'b1) begin
            failures++;
            $display("FAIL reinit_a4 got q=%h vld=%b want 05 1", q0, v0);
        end
        a = 4'd2;
        tick();
        cen = 1'b1;
        checks++;
        if (q0 !== 8'h05 || v0 !== 1'b1) begin
            failures++;
            $display("FAIL reinit_a2 got q=%h vld=%b want 05 1", q0, v0);
        end
        tick();
        tick();
    endtask

    task automatic test_parity;
        logic exp_pe;
`ifdef CT_SPSRAM_PARITY_EN
        dut0.mem[5][0] = ~dut0.mem[5][0];
        dut1.mem[5][0] = ~dut1.mem[5][0];
        exp_pe = 1'b1;
`else
        exp_pe = 1'b0;
`endif
        a = 4'd5; cen = 1'b0; gwen = 1'b1;
        tick();
        cen = 1'b1;
        checks++;
        if (pe0 !== exp_pe || v0 !== 1'b1) begin
            failures++;
            $display("FAIL parity_dut0 got perr=%b vld=%b want %b 1", pe0, v0, exp_pe);
        end
        tick();
        checks++;
        if (pe1 !== exp_pe || v1 !== 1'b1 || pe0 !== 1'b0) begin
            failures++;
            $display("FAIL parity_dut1 got perr1=%b vld1=%b perr0=%b want %b 1 0", pe1, v1, pe0, exp_pe);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_reset_mid();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
